// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter in front of a single fixed-latency RAM port.
// One transaction in flight: IDLE grants, ACCESS strobes the RAM, DONE pulses ready.
module ram_arbiter #(
   parameter int RD_LATENCY = 2,
   parameter int WR_CYCLES  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] aRamAddress,
   input  logic [31:0] aRamWrite,
   input  logic        aReadReq,
   input  logic        aWriteReq,
   output logic [31:0] aRamRead,
   output logic        aRamReady,
   input  logic [31:0] bRamAddress,
   input  logic [31:0] bRamWrite,
   input  logic        bReadReq,
   input  logic        bWriteReq,
   output logic [31:0] bRamRead,
   output logic        bRamReady,
   input  logic [31:0] phRamRead,
   output logic [31:0] phRamAddress,
   output logic [31:0] phRamWrite,
   output logic        phReadReq,
   output logic        phWriteReq,
   output logic        grantB,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] cnt;
   logic [3:0] cnt_nxt;
   logic       last_grant_b;
   logic       sel_b;
   logic       op_write;

   logic       a_pend;
   logic       b_pend;
   logic       pick_b;
   logic       pick_write;
   logic       last_cycle;

   logic       grant_now;
   logic       rd_nxt;
   logic       wr_nxt;
   logic       a_rdy_nxt;
   logic       b_rdy_nxt;
   logic       cap_a;
   logic       cap_b;
   logic       busy_nxt;

   assign a_pend = aReadReq | aWriteReq;
   assign b_pend = bReadReq | bWriteReq;

   // On a tie the port that did not win last time gets the grant.
   assign pick_b     = b_pend & (~a_pend | ~last_grant_b);
   assign pick_write = pick_b ? bWriteReq : aWriteReq;
   assign last_cycle = op_write ? (cnt == 4'(WR_CYCLES - 1))
                                : (cnt == 4'(RD_LATENCY - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (a_pend | b_pend) state_nxt = ACCESS;
         ACCESS:  if (last_cycle) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values for every registered output; strobes are only ever high in ACCESS.
   always_comb begin
      grant_now = 1'b0;
      rd_nxt    = 1'b0;
      wr_nxt    = 1'b0;
      a_rdy_nxt = 1'b0;
      b_rdy_nxt = 1'b0;
      cap_a     = 1'b0;
      cap_b     = 1'b0;
      cnt_nxt   = cnt;
      unique case (state)
         IDLE: begin
            if (a_pend | b_pend) begin
               grant_now = 1'b1;
               wr_nxt    = pick_write;
               rd_nxt    = ~pick_write;
               cnt_nxt   = 4'd0;
            end
         end
         ACCESS: begin
            if (last_cycle) begin
               cnt_nxt   = 4'd0;
               a_rdy_nxt = ~sel_b;
               b_rdy_nxt = sel_b;
               cap_a     = ~op_write & ~sel_b;
               cap_b     = ~op_write & sel_b;
            end else begin
               cnt_nxt = cnt + 4'd1;
               rd_nxt  = ~op_write;
               wr_nxt  = op_write;
            end
         end
         default: begin
         end
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   // Latched transaction, read-data capture and all registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt          <= 4'd0;
         last_grant_b <= 1'b1;
         sel_b        <= 1'b0;
         op_write     <= 1'b0;
         grantB       <= 1'b0;
         phRamAddress <= 32'd0;
         phRamWrite   <= 32'd0;
         phReadReq    <= 1'b0;
         phWriteReq   <= 1'b0;
         aRamRead     <= 32'd0;
         bRamRead     <= 32'd0;
         aRamReady    <= 1'b0;
         bRamReady    <= 1'b0;
         busy         <= 1'b0;
      end else begin
         cnt        <= cnt_nxt;
         phReadReq  <= rd_nxt;
         phWriteReq <= wr_nxt;
         aRamReady  <= a_rdy_nxt;
         bRamReady  <= b_rdy_nxt;
         busy       <= busy_nxt;
         if (grant_now) begin
            sel_b        <= pick_b;
            last_grant_b <= pick_b;
            grantB       <= pick_b;
            op_write     <= pick_write;
            phRamAddress <= pick_b ? bRamAddress : aRamAddress;
            phRamWrite   <= pick_b ? bRamWrite : aRamWrite;
         end
         if (cap_a) aRamRead <= phRamRead;
         if (cap_b) bRamRead <= phRamRead;
      end
   end

   assert property (@(posedge clk) disable iff (!reset) !(phReadReq && phWriteReq));
   assert property (@(posedge clk) disable iff (!reset) !(aRamReady && bRamReady));

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: reset, single reads/writes, ties, round-robin,
// mid-transaction reset and the read+write collision case.
module tb_ram_arbiter;

   logic        clk;
   logic        reset;
   logic [31:0] aRamAddress, aRamWrite, aRamRead;
   logic        aReadReq, aWriteReq, aRamReady;
   logic [31:0] bRamAddress, bRamWrite, bRamRead;
   logic        bReadReq, bWriteReq, bRamReady;
   logic [31:0] phRamRead, phRamAddress, phRamWrite;
   logic        phReadReq, phWriteReq, grantB, busy;

   int errors;
   int checks;

   ram_arbiter #(.RD_LATENCY(2), .WR_CYCLES(1)) dut (
      .clk(clk), .reset(reset),
      .aRamAddress(aRamAddress), .aRamWrite(aRamWrite), .aReadReq(aReadReq),
      .aWriteReq(aWriteReq), .aRamRead(aRamRead), .aRamReady(aRamReady),
      .bRamAddress(bRamAddress), .bRamWrite(bRamWrite), .bReadReq(bReadReq),
      .bWriteReq(bWriteReq), .bRamRead(bRamRead), .bRamReady(bRamReady),
      .phRamRead(phRamRead), .phRamAddress(phRamAddress), .phRamWrite(phRamWrite),
      .phReadReq(phReadReq), .phWriteReq(phWriteReq), .grantB(grantB), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 time unit after the next rising edge: the start of the next cycle.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (2) tick();
      checks++; if (aRamReady !== 1'b0) begin errors++; $display("[TB] FAIL rst_aRamReady got=%b exp=0", aRamReady); end
      checks++; if (bRamReady !== 1'b0) begin errors++; $display("[TB] FAIL rst_bRamReady got=%b exp=0", bRamReady); end
      checks++; if ({phReadReq, phWriteReq} !== 2'b00) begin errors++; $display("[TB] FAIL rst_strobes got=%b exp=00", {phReadReq, phWriteReq}); end
      checks++; if ({busy, grantB} !== 2'b00) begin errors++; $display("[TB] FAIL rst_busy_grant got=%b exp=00", {busy, grantB}); end
      checks++; if (phRamAddress !== 32'd0) begin errors++; $display("[TB] FAIL rst_phRamAddress got=%h exp=0", phRamAddress); end
      checks++; if (aRamRead !== 32'd0 || bRamRead !== 32'd0) begin errors++; $display("[TB] FAIL rst_readdata got=%h/%h exp=0/0", aRamRead, bRamRead); end
   endtask

   task automatic test_a_read;
      reset = 1'b1;
      aRamAddress = 32'h100; aReadReq = 1'b1; phRamRead = 32'hDEADBEEF;
      for (int c = 1; c <= 4; c++) begin
         tick();
         checks++; if (phReadReq !== (c == 1 || c == 2)) begin errors++; $display("[TB] FAIL a_read_phReadReq c%0d got=%b", c, phReadReq); end
         checks++; if (aRamReady !== (c == 3)) begin errors++; $display("[TB] FAIL a_read_ready c%0d got=%b", c, aRamReady); end
         checks++; if (bRamReady !== 1'b0) begin errors++; $display("[TB] FAIL a_read_bReady c%0d got=%b exp=0", c, bRamReady); end
         if (c == 1) begin
            checks++; if (phRamAddress !== 32'h100) begin errors++; $display("[TB] FAIL a_read_addr got=%h exp=100", phRamAddress); end
         end
         if (c == 3) begin
            checks++; if (aRamRead !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL a_read_data got=%h exp=deadbeef", aRamRead); end
            aReadReq = 1'b0;
         end
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL a_read_idle busy=%b exp=0", busy); end
   endtask

   task automatic test_b_write;
      bRamAddress = 32'h20; bRamWrite = 32'h12345678; bWriteReq = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         tick();
         checks++; if (phWriteReq !== (c == 1)) begin errors++; $display("[TB] FAIL b_write_phWriteReq c%0d got=%b", c, phWriteReq); end
         checks++; if (bRamReady !== (c == 2)) begin errors++; $display("[TB] FAIL b_write_ready c%0d got=%b", c, bRamReady); end
         if (c == 1) begin
            checks++; if (phRamWrite !== 32'h12345678 || phRamAddress !== 32'h20) begin errors++; $display("[TB] FAIL b_write_bus got=%h@%h exp=12345678@20", phRamWrite, phRamAddress); end
            checks++; if (grantB !== 1'b1) begin errors++; $display("[TB] FAIL b_write_grantB got=%b exp=1", grantB); end
         end
         if (c == 2) begin
            checks++; if (bRamRead !== 32'd0) begin errors++; $display("[TB] FAIL b_write_readdata got=%h exp=0", bRamRead); end
            bWriteReq = 1'b0;
         end
      end
   endtask

   task automatic test_tie;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      aRamAddress = 32'h300; bRamAddress = 32'h400;
      aReadReq = 1'b1; bReadReq = 1'b1; phRamRead = 32'hAAAA0001;
      for (int c = 1; c <= 8; c++) begin
         tick();
         checks++; if (phReadReq !== (c == 1 || c == 2 || c == 5 || c == 6)) begin errors++; $display("[TB] FAIL tie_phReadReq c%0d got=%b", c, phReadReq); end
         checks++; if (aRamReady !== (c == 3) || bRamReady !== (c == 7)) begin errors++; $display("[TB] FAIL tie_ready c%0d got a=%b b=%b", c, aRamReady, bRamReady); end
         if (c == 1) begin
            checks++; if (grantB !== 1'b0 || phRamAddress !== 32'h300) begin errors++; $display("[TB] FAIL tie_first_grant got grantB=%b addr=%h exp 0/300", grantB, phRamAddress); end
         end
         if (c == 3) aReadReq = 1'b0;
         if (c == 4) begin
            checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL tie_idle busy=%b exp=0", busy); end
            phRamRead = 32'hBBBB0002;
         end
         if (c == 5) begin
            checks++; if (grantB !== 1'b1 || phRamAddress !== 32'h400) begin errors++; $display("[TB] FAIL tie_second_grant got grantB=%b addr=%h exp 1/400", grantB, phRamAddress); end
         end
         if (c == 7) begin
            checks++; if (bRamRead !== 32'hBBBB0002 || aRamRead !== 32'hAAAA0001) begin errors++; $display("[TB] FAIL tie_data got a=%h b=%h exp aaaa0001/bbbb0002", aRamRead, bRamRead); end
            bReadReq = 1'b0;
         end
      end
   endtask

   task automatic test_round_robin;
      int n;
      int last_c;
      n = 0; last_c = 0;
      aReadReq = 1'b1; bReadReq = 1'b1;
      for (int c = 1; c <= 40 && n < 6; c++) begin
         tick();
         if (aRamReady || bRamReady) begin
            checks++; if (bRamReady !== (n % 2 == 1) || aRamReady !== (n % 2 == 0)) begin errors++; $display("[TB] FAIL rr_order txn%0d got a=%b b=%b", n, aRamReady, bRamReady); end
            checks++; if (grantB !== (n % 2 == 1)) begin errors++; $display("[TB] FAIL rr_grantB txn%0d got=%b", n, grantB); end
            if (n > 0) begin
               checks++; if (c - last_c != 4) begin errors++; $display("[TB] FAIL rr_spacing txn%0d got=%0d exp=4", n, c - last_c); end
            end else begin
               checks++; if (c != 3) begin errors++; $display("[TB] FAIL rr_first_latency got=%0d exp=3", c); end
            end
            last_c = c;
            n++;
            if (n == 6) begin aReadReq = 1'b0; bReadReq = 1'b0; end
         end
      end
      checks++; if (n != 6) begin errors++; $display("[TB] FAIL rr_timeout completions got=%0d exp=6", n); end
      aReadReq = 1'b0; bReadReq = 1'b0;
      repeat (2) tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rr_idle busy=%b exp=0", busy); end
   endtask

   task automatic test_reset_mid;
      aRamAddress = 32'h200; aReadReq = 1'b1; phRamRead = 32'h11111111;
      repeat (2) tick();
      checks++; if (phReadReq !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre_strobe got=%b exp=1", phReadReq); end
      reset = 1'b0;
      #1;
      checks++; if ({phReadReq, phWriteReq, busy, aRamReady, grantB} !== 5'b0) begin errors++; $display("[TB] FAIL mid_async_ctrl got=%b exp=00000", {phReadReq, phWriteReq, busy, aRamReady, grantB}); end
      checks++; if (phRamAddress !== 32'd0 || aRamRead !== 32'd0) begin errors++; $display("[TB] FAIL mid_async_data got addr=%h rd=%h exp 0/0", phRamAddress, aRamRead); end
      tick();
      checks++; if (aRamReady !== 1'b0) begin errors++; $display("[TB] FAIL mid_held_ready got=%b exp=0", aRamReady); end
      reset = 1'b1; phRamRead = 32'hCAFEF00D;
      for (int c = 1; c <= 4; c++) begin
         tick();
         checks++; if (aRamReady !== (c == 3)) begin errors++; $display("[TB] FAIL mid_retry_ready c%0d got=%b", c, aRamReady); end
         if (c == 3) begin
            checks++; if (aRamRead !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL mid_retry_data got=%h exp=cafef00d", aRamRead); end
            aReadReq = 1'b0;
         end
      end
   endtask

   task automatic test_read_write_both;
      int rd_seen;
      int wr_seen;
      int pulses;
      rd_seen = 0; wr_seen = 0; pulses = 0;
      aRamAddress = 32'h40; aRamWrite = 32'h0BADF00D;
      aReadReq = 1'b1; aWriteReq = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         tick();
         if (phReadReq) rd_seen++;
         if (phWriteReq) wr_seen++;
         if (c == 1) begin
            checks++; if (phRamAddress !== 32'h40 || phRamWrite !== 32'h0BADF00D) begin errors++; $display("[TB] FAIL rw_bus got=%h@%h exp=0badf00d@40", phRamWrite, phRamAddress); end
         end
         if (aRamReady) begin
            pulses++;
            aReadReq = 1'b0; aWriteReq = 1'b0;
         end
      end
      checks++; if (rd_seen != 0) begin errors++; $display("[TB] FAIL rw_no_read got=%0d exp=0", rd_seen); end
      checks++; if (wr_seen != 1) begin errors++; $display("[TB] FAIL rw_write_cycles got=%0d exp=1", wr_seen); end
      checks++; if (pulses != 1) begin errors++; $display("[TB] FAIL rw_ready_pulses got=%0d exp=1", pulses); end
      checks++; if (aRamRead !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL rw_readdata_kept got=%h exp=cafef00d", aRamRead); end
   endtask

   initial begin
      errors = 0; checks = 0;
      reset = 1'b0;
      aRamAddress = '0; aRamWrite = '0; aReadReq = 1'b0; aWriteReq = 1'b0;
      bRamAddress = '0; bRamWrite = '0; bReadReq = 1'b0; bWriteReq = 1'b0;
      phRamRead = '0;
      test_reset();
      test_a_read();
      test_b_write();
      test_tie();
      test_round_robin();
      test_reset_mid();
      test_read_write_both();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
